pc_sn_seq_popcount: RTL
=======================

// Module: pc_sn_seq_popcount
// PURPOSE
//  Sequencer that time-multiplexes one pc_sn_7_3 sorting-network parallel counter to popcount a WIDTH-bit word.
//  Accepts a word on a valid/ready input, feeds it through the counter 7 bits per cycle, and accumulates the partial counts.
//  Returns the total on a valid/ready output.
//  Sits between switch/stream logic and display/host logic on the FPGA top level; one shared counter instance is used instead of WIDTH/7 copies.
// PARAMETERS
//  WIDTH   49                  input word width in bits, >=1
//  NCHUNK  (WIDTH+6)/7         localparam: 7-bit slices per word
//  CW      $clog2(WIDTH+1)     localparam: width of out_count
// PORTS
//  clk        in   1       single clock, all state updates on rising edge
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       in_data valid
//  in_ready   out  1       block can accept a word
//  in_data    in   WIDTH   word to be counted
//  out_valid  out  1       out_count valid
//  out_ready  in   1       downstream accepts out_count
//  out_count  out  CW      number of 1s in the accepted word
//  busy       out  1       high in RUN or DONE
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, out_count=0, busy=0; shift reg, accumulator and slice index all cleared.
//  FSM: IDLE -> RUN -> DONE -> IDLE.
//  IDLE: in_ready=1.
//   - On in_valid&in_ready: latch in_data zero-extended to NCHUNK*7 bits into shift reg; acc<=0; idx<=0; go RUN.
//  RUN: in_ready=0.
//   - Each cycle: acc<=acc+pc_out, where pc_out is the pc_sn_7_3 output for shreg[6:0].
//   - Shift reg shifts right by 7; idx<=idx+1.
//   - On idx==NCHUNK-1: perform the final add and go DONE.
//  DONE: out_valid=1, out_count=acc; hold both stable until out_ready=1.
//   - On out_valid&out_ready: go IDLE, out_valid<=0.
//  Latency: accept edge to out_valid high = NCHUNK cycles (7 for default). Throughput: one word per NCHUNK+2 cycles with out_ready tied high.
//  No input accepted in RUN/DONE; in_valid held by the source is sampled at the next IDLE cycle.
//  Arithmetic: pc_out (3b) zero-extended to CW; acc is CW bits and cannot overflow because the maximum count is WIDTH.
//  Padding bits are zero and must never contribute to the count.
//  WIDTH<=7: NCHUNK=1; RUN lasts exactly one cycle.
//  out_count is registered and holds the last result after the handshake until overwritten at the next DONE.
//  out_count resets to 0.
//  out_ready high outside DONE has no effect.
//  Reset mid-operation (RUN or DONE): word discarded, out_valid drops on the same edge, no result emitted, IDLE next cycle.
// STRUCTURE
//  Shared package pc_sn_pkg:
//   - PC_IN_W=7, PC_OUT_W=3
//   - state encoding typedef: IDLE=2'd0, RUN=2'd1, DONE=2'd2
//   - function chunks(w) = (w+6)/7
//  Sub-module: one instance of the existing pc_sn_7_3, driven by shreg[6:0].
//  Everything else (FSM, shift reg, index counter, accumulator) is local to this module.
// TESTING
//  1) rst=1 for 2 cycles -> in_ready=1, out_valid=0, out_count=0, busy=0.
//  2) WIDTH=49, in_data=all ones, out_ready=1 -> out_valid exactly 7 cycles after accept; out_count=49.
//     Next word is accepted 9 cycles after the first.
//  3) WIDTH=49, in_data=49'h0_0000_0000_0001, then 49'h1_5555_5555_5555 -> out_count=1, then out_count=25.
//  4) Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and out_count stable, in_ready=0.
//     Completes the cycle after out_ready=1.
//  5) Assert rst in RUN at idx=3 -> next cycle IDLE, out_valid never asserts.
//     A following word (all zeros) yields out_count=0.
//  6) WIDTH=10, in_data=10'h3FF -> NCHUNK=2, out_count=10 after 2 cycles, with no padding contribution.
//     WIDTH=5, in_data=5'b10110 -> out_count=3 after 1 cycle.
//  Scoreboard: reference $countones on every accepted word; assert out_count stable while out_valid&!out_ready.

Source files
------------

// File: rtl/pc_sn_pkg.sv
// pc_sn_pkg: shared constants, sequencer state encoding and slice-count helper for the pc_sn counters
package pc_sn_pkg;
  localparam int PC_IN_W = 7;
  localparam int PC_OUT_W = 3;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  function automatic int chunks(input int w);
    return (w + PC_IN_W - 1) / PC_IN_W;
  endfunction
endpackage

// File: rtl/pc_sn_7_3.sv
// pc_sn_7_3: 7-input parallel counter built from an odd-even transposition sorting network
module pc_sn_7_3
  import pc_sn_pkg::*;
(
  input  logic [PC_IN_W-1:0]  d,
  output logic [PC_OUT_W-1:0] q
);
  logic [PC_IN_W-1:0] t;
  // Sorts the ones towards bit 0, giving a thermometer code of the count
  always_comb begin
    t = d;
    for (int k = 0; k < PC_IN_W; k++)
      for (int i = k % 2; i < PC_IN_W - 1; i += 2)
        t[i+:2] = {t[i] & t[i+1], t[i] | t[i+1]};
  end
  assign q = {t[3], (t[1] & ~t[3]) | t[5], (t[0] & ~t[1]) | (t[2] & ~t[3]) | (t[4] & ~t[5]) | t[6]};
endmodule

// File: rtl/pc_sn_seq_popcount.sv
// pc_sn_seq_popcount: popcounts a WIDTH-bit word 7 bits per cycle through one shared pc_sn_7_3
module pc_sn_seq_popcount
  import pc_sn_pkg::*;
#(
  parameter int WIDTH = 49
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(WIDTH+1)-1:0] out_count,
  output logic                       busy
);
  localparam int NCHUNK = chunks(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = NCHUNK * PC_IN_W;
  localparam int IW = $clog2(NCHUNK + 1);
  state_t state, state_nx;
  logic [SW-1:0] shreg;
  logic [CW-1:0] acc, acc_nx;
  logic [IW-1:0] idx;
  logic [PC_OUT_W-1:0] pc_out;
  logic last;
  pc_sn_7_3 u_pc (.d(shreg[PC_IN_W-1:0]), .q(pc_out));
  assign acc_nx = acc + CW'(pc_out);
  assign last = idx == IW'(NCHUNK - 1);
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
    busy = state != IDLE;
    state_nx = state == IDLE ? (in_valid ? RUN : IDLE) :
               state == RUN  ? (last ? DONE : RUN) :
               state == DONE ? (out_ready ? IDLE : DONE) : IDLE;
  end
  // Zero padding above WIDTH shifts in as zeros, so it never reaches the count
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      acc <= '0;
      idx <= '0;
      out_count <= '0;
    end else if (state == IDLE && in_valid) begin
      shreg <= SW'(in_data);
      acc <= '0;
      idx <= '0;
    end else if (state == RUN) begin
      shreg <= shreg >> PC_IN_W;
      acc <= acc_nx;
      idx <= idx + IW'(1);
      if (last) out_count <= acc_nx;
    end
  end
endmodule
